// File: rtl/alu_issue_ctrl.sv
// Issue controller for a multi-cycle ALU: queues commands in a small FIFO, issues them
// in order, traps divide-by-zero and stalled operations, and holds each result for the consumer.
module alu_issue_ctrl #(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic [1:0]       in_op,
    output logic [W-1:0]     alu_x,
    output logic [W-1:0]     alu_y,
    output logic [1:0]       alu_op,
    output logic             alu_start,
    input  logic [2*W-1:0]   alu_z,
    input  logic             alu_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_z,
    output logic [1:0]       out_op,
    output logic             out_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [1:0]   op;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESULT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    cmd_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_count;
    logic [TW-1:0]   r_tcnt;
    cmd_t            r_alu;
    logic            r_alu_start;
    logic [2*W-1:0]  r_out_z;
    logic [1:0]      r_out_op;
    logic            r_out_err;

    cmd_t            w_head;
    logic            w_head_dz;
    logic            w_push;
    logic            w_take;
    logic            w_pop;
    logic            w_issue;
    logic            w_dz;
    logic            w_capture;
    logic            w_timeout;

    // Acceptance depends on occupancy alone, so a full FIFO never admits a push even while popping.
    assign in_ready  = (r_count < CW'(DEPTH));
    assign w_push    = in_valid & in_ready;
    assign w_head    = r_mem[r_rp];
    assign w_head_dz = (w_head.op == 2'b11) && (w_head.y == '0);
    assign w_take    = (r_count != '0) &&
                       ((r_state == S_IDLE) || ((r_state == S_RESULT) && out_ready));

    // NOTE: every signal gets its default first so no path through the block can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_dz        = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        if (r_state == S_BUSY) begin
            if (alu_done) begin
                w_capture   = 1'b1;
                w_state_nxt = S_RESULT;
            end else if (r_tcnt == TW'(TIMEOUT)) begin
                w_timeout   = 1'b1;
                w_state_nxt = S_RESULT;
            end
        end else if (w_take) begin
            w_pop = 1'b1;
            if (w_head_dz) begin
                w_dz        = 1'b1;
                w_state_nxt = S_RESULT;
            end else begin
                w_issue     = 1'b1;
                w_state_nxt = S_BUSY;
            end
        end else if ((r_state == S_RESULT) && out_ready) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: FIFO storage has no reset; the count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {in_x, in_y, in_op};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_tcnt      <= '0;
            r_alu       <= '0;
            r_alu_start <= 1'b0;
            r_out_z     <= '0;
            r_out_op    <= '0;
            r_out_err   <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            if (w_issue) begin
                r_alu       <= w_head;
                r_alu_start <= 1'b1;
                r_tcnt      <= TW'(1);
            end else if (w_capture || w_timeout) begin
                r_alu_start <= 1'b0;
                r_tcnt      <= '0;
            end else if (r_state == S_BUSY) begin
                r_tcnt <= r_tcnt + TW'(1);
            end

            if (w_capture) begin
                r_out_z   <= alu_z;
                r_out_op  <= r_alu.op;
                r_out_err <= 1'b0;
            end else if (w_timeout) begin
                r_out_z   <= '0;
                r_out_op  <= r_alu.op;
                r_out_err <= 1'b1;
            end else if (w_dz) begin
                r_out_z   <= '1;
                r_out_op  <= 2'b11;
                r_out_err <= 1'b1;
            end
        end
    end

    assign alu_x     = r_alu.x;
    assign alu_y     = r_alu.y;
    assign alu_op    = r_alu.op;
    assign alu_start = r_alu_start;
    assign out_valid = (r_state == S_RESULT);
    assign out_z     = r_out_z;
    assign out_op    = r_out_op;
    assign out_err   = r_out_err;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus a random phase, with a behavioural ALU and
// a command-order scoreboard that predicts every result from the accepted commands.
module tb_alu_issue_ctrl;
    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;
    logic [1:0]     in_op;
    logic [W-1:0]   alu_x;
    logic [W-1:0]   alu_y;
    logic [1:0]     alu_op;
    logic           alu_start;
    logic [2*W-1:0] alu_z;
    logic           alu_done;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_z;
    logic [1:0]     out_op;
    logic           out_err;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [1:0]   op;
        logic         tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_in;
    exp_t mon_out;
    int   n_checks = 0;
    int   n_errors = 0;

    int   alu_lat   = 0;
    bit   alu_never = 1'b0;
    bit   alu_spur  = 1'b0;
    int   alu_age   = 0;

    alu_issue_ctrl #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_op(in_op),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_start(alu_start),
        .alu_z(alu_z), .alu_done(alu_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_op(out_op),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Arithmetic meaning of each opcode on zero-extended operands; x/0 yields all ones.
    function automatic logic [2*W-1:0] alu_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [1:0] op);
        logic [2*W-1:0] a;
        logic [2*W-1:0] b;
        a = {{W{1'b0}}, x};
        b = {{W{1'b0}}, y};
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return (b == '0) ? '1 : a / b;
        endcase
    endfunction

    // Behavioural ALU: done arrives alu_lat cycles into the start pulse.
    always @(posedge clk) alu_age <= alu_start ? alu_age + 1 : 0;
    assign alu_done = (alu_start && !alu_never && (alu_age == alu_lat)) || alu_spur;
    assign alu_z    = alu_f(alu_x, alu_y, alu_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted command must come back in order with the predicted result.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    mon_out = exp_q.pop_front();
                    if (mon_out.tmo) begin
                        check("res_tmo_z", 32'(out_z), 32'd0);
                        check("res_tmo_err", 32'(out_err), 32'd1);
                    end else begin
                        check("res_z", 32'(out_z), 32'(alu_f(mon_out.x, mon_out.y, mon_out.op)));
                        check("res_op", 32'(out_op), 32'(mon_out.op));
                        check("res_err", 32'(out_err),
                              32'((mon_out.op == 2'b11) && (mon_out.y == '0)));
                    end
                end
            end
            if (in_valid && in_ready) begin
                mon_in.x   = in_x;
                mon_in.y   = in_y;
                mon_in.op  = in_op;
                mon_in.tmo = alu_never && !((in_op == 2'b11) && (in_y == '0));
                exp_q.push_back(mon_in);
            end
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int acc;
        int hi;
        int nres;
        bit seen;
        logic [2*W-1:0] mul_exp [3];

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_op = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_out_z",     32'(out_z), 32'd0);
        check("rst_out_op",    32'(out_op), 32'd0);
        check("rst_out_err",   32'(out_err), 32'd0);
        check("rst_alu_xyop",  32'({alu_x, alu_y, alu_op}), 32'd0);
        rst = 1'b0;
        tick();

        // 3+4: start two edges after the push edge, result one edge later, for one cycle.
        alu_lat = 0; out_ready = 1'b1;
        in_valid = 1'b1; in_x = 8'd3; in_y = 8'd4; in_op = 2'b00;
        tick();
        in_valid = 1'b0;
        check("lat_start_early", 32'(alu_start), 32'd0);
        tick();
        check("lat_start", 32'(alu_start), 32'd1);
        check("lat_alu_operands", 32'({alu_x, alu_y, alu_op}), 32'({8'd3, 8'd4, 2'b00}));
        check("lat_valid_early", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_z", 32'(out_z), 32'h0007);
        check("lat_op_err", 32'({out_op, out_err}), 32'd0);
        tick();
        check("lat_valid_one_cycle", 32'(out_valid), 32'd0);

        // Back-pressure: 7 offered, 5 fit (one in RESULT, four queued).
        out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_x = 8'(10 + i); in_y = 8'(i + 1); in_op = 2'(i % 3);
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("full_accepted", 32'(acc), 32'd5);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
        check("full_drained", 32'(exp_q.size()), 32'd0);
        tick();
        check("full_idle_valid", 32'(out_valid), 32'd0);
        check("full_idle_ready", 32'(in_ready), 32'd1);

        // Divide by zero never reaches the ALU and is held until accepted.
        out_ready = 1'b0; seen = 1'b0;
        in_valid = 1'b1; in_x = 8'd9; in_y = 8'd0; in_op = 2'b11;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) begin
            if (alu_start) seen = 1'b1;
            tick();
        end
        check("dz_no_start", 32'(seen), 32'd0);
        check("dz_valid", 32'(out_valid), 32'd1);
        check("dz_z", 32'(out_z), 32'hFFFF);
        check("dz_op_err", 32'({out_op, out_err}), 32'b111);
        tick();
        tick();
        check("dz_held_z", 32'(out_z), 32'hFFFF);
        check("dz_held_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("dz_released", 32'(out_valid), 32'd0);

        // Stalled ALU: start held for exactly TIMEOUT cycles, then an error result.
        alu_never = 1'b1; hi = 0;
        in_valid = 1'b1; in_x = 8'd5; in_y = 8'd6; in_op = 2'b00;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (out_valid) break;
            if (alu_start) hi++;
        end
        check("tmo_start_cycles", 32'(hi), 32'(TIMEOUT));
        check("tmo_valid", 32'(out_valid), 32'd1);
        check("tmo_z", 32'(out_z), 32'd0);
        check("tmo_err", 32'(out_err), 32'd1);
        check("tmo_start_low", 32'(alu_start), 32'd0);
        tick();
        alu_never = 1'b0;
        check("tmo_released", 32'(out_valid), 32'd0);

        // A stray done with nothing in flight must not produce a result.
        alu_spur = 1'b1;
        tick();
        tick();
        tick();
        alu_spur = 1'b0;
        check("spur_no_valid", 32'(out_valid), 32'd0);
        check("spur_no_start", 32'(alu_start), 32'd0);

        // Reset while busy with two queued: everything is abandoned.
        alu_never = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_x = 8'(20 + i); in_y = 8'(3); in_op = 2'b01;
            tick();
        end
        in_valid = 1'b0;
        check("rstb_busy", 32'(alu_start), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        alu_never = 1'b0;
        check("rstb_start", 32'(alu_start), 32'd0);
        check("rstb_valid", 32'(out_valid), 32'd0);
        check("rstb_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (out_valid || alu_start) seen = 1'b1;
        end
        check("rstb_no_results", 32'(seen), 32'd0);

        // Back-to-back multiplies chain straight from RESULT into the next issue.
        alu_lat = 2; out_ready = 1'b1; nres = 0;
        mul_exp[0] = 16'd144; mul_exp[1] = 16'd65025; mul_exp[2] = 16'd6;
        in_valid = 1'b1; in_op = 2'b10;
        in_x = 8'd12;  in_y = 8'd12;  tick();
        in_x = 8'd255; in_y = 8'd255; tick();
        in_x = 8'd2;   in_y = 8'd3;   tick();
        in_valid = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (out_valid) begin
                check("mul_z", 32'(out_z), 32'(mul_exp[nres]));
                nres++;
                if (nres == 3) break;
                tick();
                check("mul_chain_start", 32'(alu_start), 32'd1);
            end
            tick();
        end
        check("mul_count", 32'(nres), 32'd3);
        tick();

        // Random traffic against the scoreboard.
        alu_lat = $urandom_range(0, 3);
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_x      = 8'($urandom);
            in_y      = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            in_op     = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 300 && (exp_q.size() != 0 || out_valid); k++) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_idle_valid", 32'(out_valid), 32'd0);
        check("rand_idle_ready", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, operand width (matches alu w).
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 16, max BUSY cycles awaiting alu_done.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  command offered.
REQ-007 in_ready  output  1  command FIFO can accept.
REQ-008 in_x, in_y  input  W each  operands.
REQ-009 in_op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-010 alu_x, alu_y  output  W each  registered operands to ALU.
REQ-011 alu_op  output  2  registered opcode to ALU.
REQ-012 alu_start  output  1  registered, high for whole ALU operation.
REQ-013 alu_z  input  2W  ALU result.
REQ-014 alu_done  input  1  ALU result valid.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_z  output  2W  captured result.
REQ-018 out_op  output  2  opcode of the result.
REQ-019 out_err  output  1  result is div-by-zero or timeout.

Function
REQ-020 FIFO SHALL hold {x,y,op}, count 0..DEPTH; in_ready = (count < DEPTH), combinational from count only; push when in_valid & in_ready.
REQ-021 When full, in_ready SHALL be 0 even if a pop occurs that cycle (no full bypass); push and pop in same cycle when not full SHALL leave count unchanged.
REQ-022 FSM states IDLE, BUSY, RESULT; encoding free.
REQ-023 IDLE & count>0 & head not div-by-zero: load head into alu_x/y/op, pop, alu_start<=1, go BUSY.
REQ-024 Div-by-zero (op 11, y==0) at head SHALL pop without ALU issue: out_z<=all ones, out_op<=11, out_err<=1, go RESULT; alu_start stays 0.
REQ-025 BUSY: alu_x/y/op, alu_start SHALL stay stable; on alu_done=1 capture out_z<=alu_z, out_op<=alu_op, out_err<=0, alu_start<=0, go RESULT.
REQ-026 BUSY cycle counter SHALL start at 1 on entry; if TIMEOUT BUSY cycles pass without alu_done: out_z<=0, out_err<=1, alu_start<=0, go RESULT.
REQ-027 alu_done SHALL be ignored outside BUSY.
REQ-028 RESULT: out_valid=1; out_z/out_op/out_err held until out_ready=1.
REQ-029 RESULT & out_ready & count>0 SHALL take the IDLE issue/div-by-zero action directly (no IDLE cycle); count==0 -> IDLE.
REQ-030 out_valid SHALL be 1 exactly in RESULT; commands complete strictly in FIFO order.
REQ-031 Latency: push at edge N into empty idle block -> alu_start high after edge N+2; alu_done in that cycle -> out_valid high after edge N+3.

Reset
REQ-032 rst=1 at an edge SHALL: FSM IDLE, count 0 (queued commands discarded), alu_start 0, out_valid 0, out_err 0, out_z 0, out_op 0, alu_x/y/op 0, timeout counter 0; in_ready=1 after.
REQ-033 Reset mid-BUSY or mid-RESULT SHALL abandon the operation; no result emitted for it.

Verification
REQ-034 Push 3+4 (op 00), ALU model done same cycle as start, out_ready=1 -> out_z=0x0007, out_op=00, out_err=0, out_valid one cycle, 3 cycles after push.
REQ-035 out_ready=0, push 7 commands back-to-back -> 5 accepted (1 in RESULT + 4 queued), in_ready=0 from then; release out_ready -> 5 results in push order.
REQ-036 Push 9/0 (op 11) -> alu_start never asserts, out_z=0xFFFF, out_op=11, out_err=1.
REQ-037 ALU model never asserts done, TIMEOUT=16 -> alu_start high exactly 16 cycles, then out_valid, out_z=0, out_err=1.
REQ-038 rst during BUSY with 2 queued -> next cycle alu_start=0, out_valid=0, in_ready=1; no results for discarded commands.
REQ-039 Three muls 12*12, 255*255, 2*3, ALU done 2 cycles after start, out_ready=1 -> out_z 0x0090, 0xFE01, 0x0006 in order, no IDLE cycle between.
